neuron_cfg_byte_streamer: RTL and testbench



---
 rtl/neuro_stream_pkg.sv | 21 ++
 rtl/neuro_sync_fifo.sv | 57 +++++
 rtl/neuron_cfg_byte_streamer.sv | 133 +++++++++++++
 tb/tb_neuron_cfg_byte_streamer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuro_stream_pkg.sv
// Shared types and constants for the neuron configuration byte streamer.
package neuro_stream_pkg;

    localparam int         ENTRY_W   = 35;
    localparam logic [7:0] TERM_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        SEND,
        GAP,
        TERM
    } state_t;

    typedef struct packed {
        logic        last;
        logic [1:0]  nbytes;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/neuro_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module neuro_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/neuron_cfg_byte_streamer.sv
// Buffers 32-bit config words and streams them MSB-first as gapped load_data byte pulses.
// Optional NEURO_STREAM_TERM_EN appends a 0x00 terminator after words marked wr_last.
module neuron_cfg_byte_streamer
    import neuro_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BYTE_GAP   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  wr_data,
    input  logic [1:0]                   wr_nbytes,
    input  logic                         wr_last,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         flush,
    output logic [7:0]                   data,
    output logic                         load_data,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'((BYTE_GAP > 1) ? (BYTE_GAP - 2) : 0);

    state_t        state;
    state_t        state_n;
    state_t        after_word;
    entry_t        head;
    entry_t        wr_entry;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          more;
    logic [31:0]   shift;
    logic [2:0]    byte_cnt;
    logic          last_q;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    data_hold;

    assign wr_entry = '{last: wr_last, nbytes: wr_nbytes, data: wr_data};
    assign wr_ready = !fifo_full;
    assign push     = wr_valid && wr_ready && !flush;
    assign pop      = (state == POP) && !flush;

    neuro_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign load_data = (state == SEND) || (state == TERM);
    assign data      = (state == SEND) ? shift[31:24] :
                       (state == TERM) ? TERM_BYTE    : data_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // byte_cnt counts bytes still to send including the one in SEND, so in
    // SEND "more to come" means the counter is above 1.
    always_comb begin
        more       = (state == SEND) ? (byte_cnt != 3'd1) : (byte_cnt != 3'd0);
        after_word = fifo_empty ? IDLE : POP;
        if (more) after_word = SEND;
`ifdef NEURO_STREAM_TERM_EN
        else if (last_q) after_word = TERM;
`endif
        state_n = state;
        case (state)
            IDLE:    if (!fifo_empty) state_n = POP;
            POP:     state_n = SEND;
            SEND:    state_n = (BYTE_GAP > 1) ? GAP : after_word;
            GAP:     if (gap_cnt == '0) state_n = after_word;
            TERM:    state_n = fifo_empty ? IDLE : POP;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift     <= '0;
            byte_cnt  <= '0;
            last_q    <= 1'b0;
            gap_cnt   <= '0;
            data_hold <= '0;
        end else if (flush) begin
            data_hold <= '0;
            last_q    <= 1'b0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                POP: begin
                    shift    <= head.data;
                    byte_cnt <= {1'b0, head.nbytes} + 3'd1;
                    last_q   <= head.last;
                end
                SEND: begin
                    data_hold <= shift[31:24];
                    shift     <= shift << 8;
                    byte_cnt  <= byte_cnt - 3'd1;
                    gap_cnt   <= GAP_INIT;
                end
                GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                TERM: begin
                    data_hold <= TERM_BYTE;
                    last_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifndef NEURO_STREAM_TERM_EN
    // wr_last is carried through the FIFO but has no effect in this build.
    logic unused_last;
    assign unused_last = last_q;
`endif

endmodule

// File: tb/tb_neuron_cfg_byte_streamer.sv
// Self-checking bench: vector table, hand sequences, random stream vs byte-list model.
module tb_neuron_cfg_byte_streamer;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
`ifdef NEURO_STREAM_TERM_EN
    localparam bit TERM_EN = 1'b1;
`else
    localparam bit TERM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_nbytes = '0;
    logic        wr_last = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic        flush = 1'b0;
    logic [7:0]  data;
    logic        load_data;
    logic        busy;
    logic [3:0]  fifo_count;

    neuron_cfg_byte_streamer #(.FIFO_DEPTH(DEPTH), .BYTE_GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_nbytes  (wr_nbytes),
        .wr_last    (wr_last),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .data       (data),
        .load_data  (load_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_b[$];
    int         got_t[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && load_data) begin
            got_b.push_back(data);
            got_t.push_back(cyc);
        end
    end

    typedef struct {
        logic [31:0] d;
        logic [1:0]  n;
        logic        l;
        int          nb;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_word(input logic [31:0] d, input logic [1:0] n, input logic l);
        for (int k = 0; k <= int'(n); k++) exp_q.push_back(d[31-8*k -: 8]);
        if (TERM_EN && l) exp_q.push_back(8'h00);
    endfunction

    task automatic write_word(input logic [31:0] d, input logic [1:0] n, input logic l, output int t);
        bit ok;
        t = -1;
        wr_data = d; wr_nbytes = n; wr_last = l; wr_valid = 1'b1;
        for (int i = 0; i < 300 && t < 0; i++) begin
            @(negedge clk); ok = wr_ready;
            @(posedge clk); #1;
            if (ok) t = cyc;
        end
        wr_valid = 1'b0;
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL write_accept: got timeout expected accept");
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic check_stream(input string name);
        chk({name, "_len"}, 32'(got_b.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_b.size(); k++)
            if (got_b[k] !== exp_q[k]) chk($sformatf("%s_b%0d", name, k), 32'(got_b[k]), 32'(exp_q[k]));
        checks++;
    endtask

    vec_t vecs[6];
    int   t, t9, nexp;
    logic [31:0] e;
    logic [7:0]  eb;

    initial begin
        vecs[0] = '{32'hFF380001, 2'd3, 1'b0, 4, 32'hFF380001};
        vecs[1] = '{32'hAF000000, 2'd0, 1'b0, 1, 32'hAF000000};
        vecs[2] = '{32'h12345678, 2'd1, 1'b0, 2, 32'h12340000};
        vecs[3] = '{32'hDEADBEEF, 2'd2, 1'b0, 3, 32'hDEADBE00};
        vecs[4] = '{32'hA5C3_5A3C, 2'd3, 1'b1, 4, 32'hA5C35A3C};
        vecs[5] = '{32'hFE3F0000, 2'd1, 1'b1, 2, 32'hFE3F0000};

        // Reset with a write pending.
        wr_valid = 1'b1; wr_data = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_load_data", 32'(load_data), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        wr_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Vector table: bytes and pulse timing relative to the accept edge.
        for (int v = 0; v < 6; v++) begin
            got_b.delete(); got_t.delete();
            write_word(vecs[v].d, vecs[v].n, vecs[v].l, t);
            wait_idle(100, $sformatf("vec%0d_idle", v));
            nexp = vecs[v].nb + ((TERM_EN && vecs[v].l) ? 1 : 0);
            chk($sformatf("vec%0d_count", v), 32'(got_b.size()), 32'(nexp));
            e = vecs[v].exp;
            for (int k = 0; k < nexp && k < got_b.size(); k++) begin
                eb = (k < vecs[v].nb) ? e[31-8*k -: 8] : 8'h00;
                chk($sformatf("vec%0d_byte%0d", v, k), 32'(got_b[k]), 32'(eb));
                chk($sformatf("vec%0d_time%0d", v, k), 32'(got_t[k] - t), 32'(2 + GAP*k));
            end
            @(posedge clk); #1;
        end

        // Partial word then full word: POP adds one cycle between words.
        got_b.delete(); got_t.delete(); exp_q.delete();
        write_word(32'hAF000000, 2'd0, 1'b0, t);
        write_word(32'h02030405, 2'd3, 1'b0, t);
        model_word(32'hAF000000, 2'd0, 1'b0);
        model_word(32'h02030405, 2'd3, 1'b0);
        wait_idle(100, "part_idle");
        check_stream("part");
        if (got_t.size() >= 3) begin
            chk("part_gap_word", 32'(got_t[1] - got_t[0]), 32'(GAP + 1));
            chk("part_gap_byte", 32'(got_t[2] - got_t[1]), 32'(GAP));
        end
        @(posedge clk); #1;

        // Backpressure: ten 4-byte words pushed back to back.
        got_b.delete(); got_t.delete(); exp_q.delete();
        for (int w = 0; w < 10; w++) begin
            e = $urandom;
            write_word(e, 2'd3, 1'b0, t);
            model_word(e, 2'd3, 1'b0);
            if (w == 8) begin
                t9 = t;
                chk("bp_full_count", 32'(fifo_count), 32'(DEPTH));
                chk("bp_wr_ready", 32'(wr_ready), 32'd0);
            end
        end
        chk("bp_held", 32'(t - t9 > 1), 32'd1);
        wait_idle(1000, "bp_idle");
        check_stream("bp");
        @(posedge clk); #1;

        // Flush after the second byte with three words queued; a same-cycle write is dropped.
        got_b.delete(); got_t.delete();
        for (int w = 0; w < 4; w++) write_word(32'h11223344 + w, 2'd3, 1'b0, t);
        t = 0;
        for (int i = 0; i < 50 && got_b.size() < 2; i++) begin
            @(negedge clk); #1;
            t = i;
        end
        chk("fl_pre_bytes", 32'(got_b.size()), 32'd2);
        chk("fl_pre_count", 32'(fifo_count), 32'd3);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 32'hCAFE0000; wr_nbytes = 2'd1;
        @(posedge clk); #1;
        flush = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        chk("fl_count", 32'(fifo_count), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_load", 32'(load_data), 32'd0);
        chk("fl_data", 32'(data), 32'd0);
        repeat (30) @(negedge clk);
        chk("fl_no_more", 32'(got_b.size()), 32'd2);
        @(posedge clk); #1;

        // Random words with random idle time, checked against the byte-list model.
        got_b.delete(); got_t.delete(); exp_q.delete();
        for (int w = 0; w < 40; w++) begin
            e = $urandom;
            eb = 8'($urandom);
            write_word(e, eb[1:0], eb[2], t);
            model_word(e, eb[1:0], eb[2]);
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        wait_idle(3000, "rnd_idle");
        check_stream("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
